cheri_setb_trap_unit: RTL and testbench
=======================================

Name: cheri_setb_trap_unit

Overview:
- Multi-channel capability set-bounds unit for the amber CHERI datapath; arbitrates up to NCH requesters (e.g. CSETB / CSETBiv issue paths).
- Validates tag, SB permission, length and bounds monotonicity, then returns either the narrowed capability or a trap response.
- Keeps a sticky first-trap record (cause + faulting PC, LR-style) plus a saturating trap counter for the trap/SR logic.

Parameters:
- W, 48, address/length width.
- PERM_W, 24, permission field width.
- SB_BIT, 0, index of the set-bounds permission bit in perms.
- NCH, 2, number of request channels (>=1); CHW = max(1, $clog2(NCH)).
- ALLOW_ZERO_LEN, 0, when 1, req_len==0 is legal.

Ports:
- r_clk  in  1  clock.
- r_rst  in  1  reset, asynchronous, active-low.
- i_req_valid  in  NCH  per-channel request valid.
- o_req_ready  out  NCH  per-channel accept (one-hot or zero).
- i_req_pc  in  NCH*W  PC of requesting instruction.
- i_cap_base / i_cap_len / i_cap_cur  in  NCH*W each  source capability fields.
- i_cap_perms  in  NCH*PERM_W  source perms.
- i_cap_attr  in  NCH*PERM_W  source attr.
- i_cap_tag  in  NCH  source tag.
- i_req_len  in  NCH*W  requested length.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response accept.
- o_rsp_ch  out  CHW  channel of response.
- o_rsp_base / o_rsp_len / o_rsp_cur  out  W each  result capability.
- o_rsp_perms / o_rsp_attr  out  PERM_W each  result perms/attr.
- o_rsp_tag  out  1  result tag.
- o_rsp_trap  out  1  response is a trap.
- o_rsp_cause  out  3  cause of this response.
- i_trap_clr  in  1  clear sticky record.
- o_trap_valid  out  1  sticky record holds a trap.
- o_trap_cause  out  3  sticky cause.
- o_trap_pc  out  W  sticky faulting PC.
- o_trap_count  out  16  saturating trap count.

Behaviour:
- Reset (r_rst low, async): state IDLE, all outputs 0, RR pointer = NCH-1 (channel 0 wins first).
- FSM IDLE -> CHECK -> RESP -> IDLE.
- IDLE: grant the first valid channel after the RR pointer (wrapping); o_req_ready high only for that channel, combinational from i_req_valid. On handshake (edge T): latch all fields of the granted channel, pointer := granted, go CHECK. No valid: stay IDLE, ready all 0.
- CHECK (T+1): compute result/cause into registers, go RESP.
- RESP: o_rsp_valid=1 from T+2; outputs stable until handshake with i_rsp_ready; then IDLE. o_req_ready is 0 outside IDLE. Throughput: one request per 3 cycles minimum.
- Cause codes: 0 none, 1 TAG, 2 PERM, 3 LEN, 4 BOUNDS; priority TAG > PERM > LEN > BOUNDS.
  - TAG: tag==0.
  - PERM: perms[SB_BIT]==0.
  - LEN: req_len==0 and ALLOW_ZERO_LEN==0.
  - BOUNDS: arithmetic in W+1 bits; old_end = base+len, new_end = cur+req_len. Fail if cur<base or new_end>old_end. new_end==old_end passes. Overflow past 2^W is caught by the W+1 compare.
- No trap: base=cur, len=req_len, cur=cur, perms/attr unchanged, tag=1, trap=0, cause=0.
- Trap: trap=1, cause set, cap fields echo source unchanged, tag=0.
- Sticky record, updated on the response handshake edge when trap=1:
  - If o_trap_valid==0: capture cause and pc, valid:=1. First trap wins; later traps are not captured.
  - o_trap_count increments on every trap, saturating at 16'hFFFF.
  - i_trap_clr clears valid/cause/pc to 0; count is cleared only by reset.
  - i_trap_clr coincident with a trap handshake: record the new trap (valid=1).
- Reset mid-operation discards the in-flight request; no response is issued.

Test Plan:
- Ch0 base=100 len=50 cur=110 perms=1<<SB_BIT tag=1 req_len=0 pc=0x40 -> o_rsp_valid at T+2, trap=1, cause=3, o_trap_valid=1, o_trap_pc=0x40, count=1.
- Same cap, req_len=40 -> no trap, base=110 len=40 cur=110 tag=1; req_len=41 -> cause=4; ALLOW_ZERO_LEN=1 with req_len=0 -> no trap, len=0.
- tag=0, perms=0, req_len=0 -> cause=1 (priority); tag=1, perms=0 -> cause=2.
- Ch0 and ch1 valid continuously, four requests -> grant order 0,1,0,1, one grant per 3 cycles; i_rsp_ready held low 5 cycles -> response fields stable, no new grant.
- Trap pc=0x40 then trap pc=0x80 -> o_trap_pc stays 0x40, count=2; i_trap_clr on the 0x80 handshake edge -> o_trap_pc=0x80, valid=1.
- Assert reset during CHECK -> all outputs 0 immediately, no o_rsp_valid after release, next grant goes to ch0.

Source files
------------

// File: rtl/cheri_setb_trap_unit_if.sv
// Request/response/trap-record bundle for the capability set-bounds unit.
// The requester side drives i_* and the unit drives o_*.
interface cheri_setb_trap_unit_if #(
  parameter int W      = 48,
  parameter int PERM_W = 24,
  parameter int NCH    = 2
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]        i_req_valid;
  logic [NCH-1:0]        o_req_ready;
  logic [NCH*W-1:0]      i_req_pc;
  logic [NCH*W-1:0]      i_cap_base;
  logic [NCH*W-1:0]      i_cap_len;
  logic [NCH*W-1:0]      i_cap_cur;
  logic [NCH*PERM_W-1:0] i_cap_perms;
  logic [NCH*PERM_W-1:0] i_cap_attr;
  logic [NCH-1:0]        i_cap_tag;
  logic [NCH*W-1:0]      i_req_len;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [CHW-1:0]        o_rsp_ch;
  logic [W-1:0]          o_rsp_base;
  logic [W-1:0]          o_rsp_len;
  logic [W-1:0]          o_rsp_cur;
  logic [PERM_W-1:0]     o_rsp_perms;
  logic [PERM_W-1:0]     o_rsp_attr;
  logic                  o_rsp_tag;
  logic                  o_rsp_trap;
  logic [2:0]            o_rsp_cause;

  logic                  i_trap_clr;
  logic                  o_trap_valid;
  logic [2:0]            o_trap_cause;
  logic [W-1:0]          o_trap_pc;
  logic [15:0]           o_trap_count;

  modport master (
    output i_req_valid, i_req_pc, i_cap_base, i_cap_len, i_cap_cur,
           i_cap_perms, i_cap_attr, i_cap_tag, i_req_len, i_rsp_ready, i_trap_clr,
    input  o_req_ready, o_rsp_valid, o_rsp_ch, o_rsp_base, o_rsp_len, o_rsp_cur,
           o_rsp_perms, o_rsp_attr, o_rsp_tag, o_rsp_trap, o_rsp_cause,
           o_trap_valid, o_trap_cause, o_trap_pc, o_trap_count
  );

  modport slave (
    input  i_req_valid, i_req_pc, i_cap_base, i_cap_len, i_cap_cur,
           i_cap_perms, i_cap_attr, i_cap_tag, i_req_len, i_rsp_ready, i_trap_clr,
    output o_req_ready, o_rsp_valid, o_rsp_ch, o_rsp_base, o_rsp_len, o_rsp_cur,
           o_rsp_perms, o_rsp_attr, o_rsp_tag, o_rsp_trap, o_rsp_cause,
           o_trap_valid, o_trap_cause, o_trap_pc, o_trap_count
  );
endinterface

// File: rtl/cheri_setb_trap_unit.sv
// Round-robin CSETB unit: validates tag/perm/length/bounds, returns the narrowed
// capability or a trap, and keeps a sticky first-trap record plus trap counter.
module cheri_setb_trap_unit #(
  parameter int W              = 48,
  parameter int PERM_W         = 24,
  parameter int SB_BIT         = 0,
  parameter int NCH            = 2,
  parameter int ALLOW_ZERO_LEN = 0
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  cheri_setb_trap_unit_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] C_NONE   = 3'd0;
  localparam logic [2:0] C_TAG    = 3'd1;
  localparam logic [2:0] C_PERM   = 3'd2;
  localparam logic [2:0] C_LEN    = 3'd3;
  localparam logic [2:0] C_BOUNDS = 3'd4;

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, RESP = 2'd2} state_t;

  state_t state_q, state_d;

  logic [CHW-1:0]    ptr_q, gnt_idx, ch_q;
  logic              gnt_found;
  logic [NCH-1:0]    above_ptr, ready;

  logic [W-1:0]      sel_pc, sel_base, sel_len, sel_cur, sel_rlen;
  logic [PERM_W-1:0] sel_perms, sel_attr;
  logic              sel_tag;

  logic [W-1:0]      pc_q, base_q, len_q, cur_q, rlen_q;
  logic [PERM_W-1:0] perms_q, attr_q;
  logic              tag_q;

  logic [W:0]        old_end, new_end;
  logic [2:0]        cause_d;

  logic [W-1:0]      rsp_base_q, rsp_len_q, rsp_cur_q;
  logic [PERM_W-1:0] rsp_perms_q, rsp_attr_q;
  logic              rsp_tag_q, rsp_trap_q;
  logic [2:0]        rsp_cause_q;

  logic              trap_valid_q;
  logic [2:0]        trap_cause_q;
  logic [W-1:0]      trap_pc_q;
  logic [15:0]       trap_count_q;
  logic              trap_hs;

  // Grant the lowest valid channel above the pointer, else wrap to the lowest valid.
  always_comb begin
    above_ptr = '0;
    for (int c = 0; c < NCH; c++) begin
      above_ptr[c] = bus.i_req_valid[c] && (c > int'(ptr_q));
    end
    gnt_found = |bus.i_req_valid;
    gnt_idx   = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (bus.i_req_valid[c]) gnt_idx = CHW'(c);
    end
    if (|above_ptr) begin
      for (int c = NCH - 1; c >= 0; c--) begin
        if (above_ptr[c]) gnt_idx = CHW'(c);
      end
    end
  end

  always_comb begin
    ready     = '0;
    sel_pc    = '0;
    sel_base  = '0;
    sel_len   = '0;
    sel_cur   = '0;
    sel_rlen  = '0;
    sel_perms = '0;
    sel_attr  = '0;
    sel_tag   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt_idx == CHW'(c)) begin
        // Ready is held low while reset is asserted so every output reads zero.
        ready[c]  = r_rst && (state_q == IDLE) && gnt_found;
        sel_pc    = bus.i_req_pc[c*W +: W];
        sel_base  = bus.i_cap_base[c*W +: W];
        sel_len   = bus.i_cap_len[c*W +: W];
        sel_cur   = bus.i_cap_cur[c*W +: W];
        sel_rlen  = bus.i_req_len[c*W +: W];
        sel_perms = bus.i_cap_perms[c*PERM_W +: PERM_W];
        sel_attr  = bus.i_cap_attr[c*PERM_W +: PERM_W];
        sel_tag   = bus.i_cap_tag[c];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_found) state_d = CHECK;
      CHECK:   state_d = RESP;
      RESP:    if (bus.i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      ptr_q   <= CHW'(NCH - 1);
      ch_q    <= '0;
      pc_q    <= '0;
      base_q  <= '0;
      len_q   <= '0;
      cur_q   <= '0;
      rlen_q  <= '0;
      perms_q <= '0;
      attr_q  <= '0;
      tag_q   <= 1'b0;
    end else if (state_q == IDLE && gnt_found) begin
      ptr_q   <= gnt_idx;
      ch_q    <= gnt_idx;
      pc_q    <= sel_pc;
      base_q  <= sel_base;
      len_q   <= sel_len;
      cur_q   <= sel_cur;
      rlen_q  <= sel_rlen;
      perms_q <= sel_perms;
      attr_q  <= sel_attr;
      tag_q   <= sel_tag;
    end
  end

  // One extra bit on both ends means a wrap past 2^W always reads as out of bounds.
  always_comb begin
    old_end = {1'b0, base_q} + {1'b0, len_q};
    new_end = {1'b0, cur_q} + {1'b0, rlen_q};
    if (!tag_q)                                         cause_d = C_TAG;
    else if (!perms_q[SB_BIT])                          cause_d = C_PERM;
    else if ((ALLOW_ZERO_LEN == 0) && (rlen_q == '0))   cause_d = C_LEN;
    else if ((cur_q < base_q) || (new_end > old_end))   cause_d = C_BOUNDS;
    else                                                cause_d = C_NONE;
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      rsp_base_q  <= '0;
      rsp_len_q   <= '0;
      rsp_cur_q   <= '0;
      rsp_perms_q <= '0;
      rsp_attr_q  <= '0;
      rsp_tag_q   <= 1'b0;
      rsp_trap_q  <= 1'b0;
      rsp_cause_q <= '0;
    end else if (state_q == CHECK) begin
      rsp_perms_q <= perms_q;
      rsp_attr_q  <= attr_q;
      rsp_cur_q   <= cur_q;
      rsp_cause_q <= cause_d;
      rsp_trap_q  <= (cause_d != C_NONE);
      rsp_tag_q   <= (cause_d == C_NONE);
      rsp_base_q  <= (cause_d == C_NONE) ? cur_q  : base_q;
      rsp_len_q   <= (cause_d == C_NONE) ? rlen_q : len_q;
    end
  end

  assign trap_hs = (state_q == RESP) && bus.i_rsp_ready && rsp_trap_q;

  // A clear arriving with a trap handshake still records that trap.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      trap_valid_q <= 1'b0;
      trap_cause_q <= '0;
      trap_pc_q    <= '0;
      trap_count_q <= '0;
    end else begin
      if (trap_hs && (!trap_valid_q || bus.i_trap_clr)) begin
        trap_valid_q <= 1'b1;
        trap_cause_q <= rsp_cause_q;
        trap_pc_q    <= pc_q;
      end else if (bus.i_trap_clr) begin
        trap_valid_q <= 1'b0;
        trap_cause_q <= '0;
        trap_pc_q    <= '0;
      end
      if (trap_hs && (trap_count_q != 16'hFFFF)) trap_count_q <= trap_count_q + 16'd1;
    end
  end

  assign bus.o_req_ready  = ready;
  assign bus.o_rsp_valid  = (state_q == RESP);
  assign bus.o_rsp_ch     = ch_q;
  assign bus.o_rsp_base   = rsp_base_q;
  assign bus.o_rsp_len    = rsp_len_q;
  assign bus.o_rsp_cur    = rsp_cur_q;
  assign bus.o_rsp_perms  = rsp_perms_q;
  assign bus.o_rsp_attr   = rsp_attr_q;
  assign bus.o_rsp_tag    = rsp_tag_q;
  assign bus.o_rsp_trap   = rsp_trap_q;
  assign bus.o_rsp_cause  = rsp_cause_q;
  assign bus.o_trap_valid = trap_valid_q;
  assign bus.o_trap_cause = trap_cause_q;
  assign bus.o_trap_pc    = trap_pc_q;
  assign bus.o_trap_count = trap_count_q;
endmodule

// File: tb/tb_cheri_setb_trap_unit.sv
// Bench for cheri_setb_trap_unit: directed cases plus randomized traffic against
// a transaction-level model of arbitration, bounds rules and the trap record.
module tb_cheri_setb_trap_unit;
  localparam int W = 48, PERM_W = 24, SB_BIT = 0, NCH = 2, CHW = 1;

  logic r_clk = 1'b0;
  logic r_rst = 1'b0;
  always #5 r_clk = ~r_clk;

  cheri_setb_trap_unit_if #(.W(W), .PERM_W(PERM_W), .NCH(NCH)) bus ();
  cheri_setb_trap_unit_if #(.W(W), .PERM_W(PERM_W), .NCH(NCH)) bus_z ();

  cheri_setb_trap_unit #(.W(W), .PERM_W(PERM_W), .SB_BIT(SB_BIT), .NCH(NCH), .ALLOW_ZERO_LEN(0))
    dut (.r_clk(r_clk), .r_rst(r_rst), .bus(bus));
  cheri_setb_trap_unit #(.W(W), .PERM_W(PERM_W), .SB_BIT(SB_BIT), .NCH(NCH), .ALLOW_ZERO_LEN(1))
    dut_z (.r_clk(r_clk), .r_rst(r_rst), .bus(bus_z));

  typedef struct {
    logic              valid;
    logic [W-1:0]      pc, base, len, cur, rlen;
    logic [PERM_W-1:0] perms, attr;
    logic              tag;
  } req_t;

  typedef struct {
    logic [CHW-1:0]    ch;
    logic [W-1:0]      base, len, cur;
    logic [PERM_W-1:0] perms, attr;
    logic              tag, trap;
    logic [2:0]        cause;
  } rsp_t;

  req_t rq [NCH];
  logic rsp_ready, trap_clr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  bit           m_busy;
  int           m_age, m_ptr, m_cnt, acc_ch;
  rsp_t         m_exp;
  logic [W-1:0] m_exp_pc, m_tpc;
  bit           m_tv;
  logic [2:0]   m_tc;

  // observations of the DUT
  bit           obs_rv;
  int           glog_ch[$], glog_cyc[$];
  logic         last_trap, last_tag;
  logic [2:0]   last_cause;
  logic [W-1:0] last_base, last_len, last_cur;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t model_rsp(int c, req_t r, int azl);
    rsp_t o;
    longint unsigned b, l, cu, rl;
    b = 64'(r.base); l = 64'(r.len); cu = 64'(r.cur); rl = 64'(r.rlen);
    if (!r.tag)                      o.cause = 3'd1;
    else if (!r.perms[SB_BIT])       o.cause = 3'd2;
    else if (rl == 0 && azl == 0)    o.cause = 3'd3;
    else if (cu < b || cu + rl > b + l) o.cause = 3'd4;
    else                             o.cause = 3'd0;
    o.ch = CHW'(c);
    o.perms = r.perms;
    o.attr = r.attr;
    o.trap = (o.cause != 3'd0);
    o.tag = !o.trap;
    o.base = o.trap ? r.base : r.cur;
    o.len = o.trap ? r.len : r.rlen;
    o.cur = r.cur;
    return o;
  endfunction

  function automatic logic [255:0] pack_rsp(rsp_t r);
    return 256'({r.ch, r.base, r.len, r.cur, r.perms, r.attr, r.tag, r.trap, r.cause});
  endfunction

  function automatic logic [255:0] dut_rsp();
    return 256'({bus.o_rsp_ch, bus.o_rsp_base, bus.o_rsp_len, bus.o_rsp_cur, bus.o_rsp_perms,
                 bus.o_rsp_attr, bus.o_rsp_tag, bus.o_rsp_trap, bus.o_rsp_cause});
  endfunction

  function automatic int model_grant();
    if (m_busy) return -1;
    for (int k = 1; k <= NCH; k++) begin
      if (rq[(m_ptr + k) % NCH].valid) return (m_ptr + k) % NCH;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      bus.i_req_valid[c]                  = rq[c].valid;
      bus.i_req_pc[c*W +: W]              = rq[c].pc;
      bus.i_cap_base[c*W +: W]            = rq[c].base;
      bus.i_cap_len[c*W +: W]             = rq[c].len;
      bus.i_cap_cur[c*W +: W]             = rq[c].cur;
      bus.i_req_len[c*W +: W]             = rq[c].rlen;
      bus.i_cap_perms[c*PERM_W +: PERM_W] = rq[c].perms;
      bus.i_cap_attr[c*PERM_W +: PERM_W]  = rq[c].attr;
      bus.i_cap_tag[c]                    = rq[c].tag;
    end
    bus.i_rsp_ready = rsp_ready;
    bus.i_trap_clr  = trap_clr;
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_ptr = NCH - 1; m_cnt = 0; acc_ch = -1;
    m_tv = 0; m_tc = '0; m_tpc = '0;
  endtask

  task automatic check_outputs();
    int g;
    logic [NCH-1:0] er;
    bit erv;
    g = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 256'(bus.o_req_ready), 256'(er));
    erv = m_busy && m_age >= 1;
    chk("rsp_valid", 256'(bus.o_rsp_valid), 256'(erv));
    if (erv) chk("rsp_fields", dut_rsp(), pack_rsp(m_exp));
    chk("trap_rec", 256'({bus.o_trap_valid, bus.o_trap_cause, bus.o_trap_pc, bus.o_trap_count}),
        256'({m_tv, m_tc, m_tpc, 16'(m_cnt)}));
    obs_rv = bus.o_rsp_valid;
    for (int c = 0; c < NCH; c++) begin
      if (bus.o_req_ready[c]) begin glog_ch.push_back(c); glog_cyc.push_back(cyc); end
    end
    if (bus.o_rsp_valid && rsp_ready) begin
      last_trap = bus.o_rsp_trap; last_cause = bus.o_rsp_cause; last_tag = bus.o_rsp_tag;
      last_base = bus.o_rsp_base; last_len = bus.o_rsp_len; last_cur = bus.o_rsp_cur;
    end
  endtask

  task automatic model_advance();
    int g;
    bit hs, was_busy;
    g = model_grant();
    was_busy = m_busy;
    hs = m_busy && m_age >= 1 && rsp_ready;
    acc_ch = -1;
    if (hs && m_exp.trap && m_cnt < 65535) m_cnt++;
    if (hs && m_exp.trap && (!m_tv || trap_clr)) begin
      m_tv = 1; m_tc = m_exp.cause; m_tpc = m_exp_pc;
    end else if (trap_clr) begin
      m_tv = 0; m_tc = '0; m_tpc = '0;
    end
    if (hs) m_busy = 0;
    else if (m_busy) m_age++;
    if (!was_busy && g >= 0) begin
      m_busy = 1; m_age = 0; m_ptr = g; acc_ch = g;
      m_exp = model_rsp(g, rq[g], 0);
      m_exp_pc = rq[g].pc;
    end
  endtask

  // Called at a falling edge with stimulus set up; returns at the next falling edge.
  task automatic step();
    drive();
    #1;
    check_outputs();
    model_advance();
    @(posedge r_clk);
    cyc++;
    @(negedge r_clk);
  endtask

  task automatic apply_reset();
    r_rst = 1'b0;
    drive();
    #1;
    chk("rst_ready", 256'(bus.o_req_ready), 256'(0));
    chk("rst_rsp_valid", 256'(bus.o_rsp_valid), 256'(0));
    chk("rst_rsp_fields", dut_rsp(), 256'(0));
    chk("rst_trap_rec", 256'({bus.o_trap_valid, bus.o_trap_cause, bus.o_trap_pc, bus.o_trap_count}), 256'(0));
    model_reset();
    repeat (2) @(negedge r_clk);
    for (int c = 0; c < NCH; c++) rq[c].valid = 1'b0;
    drive();
    r_rst = 1'b1;
  endtask

  task automatic set_req(int c, logic [W-1:0] base, logic [W-1:0] len, logic [W-1:0] cur,
                         logic [PERM_W-1:0] perms, logic tag, logic [W-1:0] rlen, logic [W-1:0] pc);
    rq[c].valid = 1'b1; rq[c].base = base; rq[c].len = len; rq[c].cur = cur;
    rq[c].perms = perms; rq[c].attr = 24'hA5A5A5; rq[c].tag = tag; rq[c].rlen = rlen; rq[c].pc = pc;
  endtask

  task automatic issue(int c, logic [W-1:0] base, logic [W-1:0] len, logic [W-1:0] cur,
                       logic [PERM_W-1:0] perms, logic tag, logic [W-1:0] rlen,
                       logic [W-1:0] pc, bit clr_on_hs);
    bit done, hs_pred;
    int t_acc, t_rv;
    done = 0; t_acc = -1; t_rv = -1;
    set_req(c, base, len, cur, perms, tag, rlen, pc);
    rsp_ready = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      hs_pred = m_busy && m_age >= 1 && rsp_ready;
      trap_clr = clr_on_hs && hs_pred;
      step();
      if (acc_ch >= 0) begin rq[acc_ch].valid = 1'b0; t_acc = cyc - 1; end
      if (obs_rv && t_rv < 0) t_rv = cyc - 1;
      if (hs_pred) done = 1;
    end
    trap_clr = 1'b0;
    chk("issue_done", 256'(done), 256'(1));
    chk("rsp_latency", 256'(t_rv - t_acc), 256'(2));
  endtask

  function automatic logic [W-1:0] r48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic rand_req(int c);
    logic [W-1:0] b, l, cu, rl;
    b  = ($urandom % 4 == 0) ? (~W'(0) - W'($urandom % 256)) : r48();
    l  = ($urandom % 2 == 1) ? W'($urandom % 512) : r48();
    cu = ($urandom % 8 == 0) ? b - W'($urandom % 4 + 1) : b + W'($urandom % 600);
    case ($urandom % 4)
      0:       rl = '0;
      1:       rl = b + l - cu;
      2:       rl = b + l - cu + W'(1);
      default: rl = W'($urandom % 512);
    endcase
    set_req(c, b, l, cu, PERM_W'($urandom), ($urandom % 10 != 0), rl, r48());
    rq[c].perms[SB_BIT] = ($urandom % 8 != 0);
    rq[c].attr = PERM_W'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit zl_seen;
    logic zl_trap, zl_tag;
    logic [W-1:0] zl_len;
    logic [255:0] snap;
    for (int c = 0; c < NCH; c++) begin
      set_req(c, '0, '0, '0, '0, 1'b0, '0, '0);
      rq[c].valid = 1'b0;
    end
    rsp_ready = 1'b0; trap_clr = 1'b0;
    drive();
    bus_z.i_req_valid = '0; bus_z.i_req_pc = '0; bus_z.i_cap_base = '0; bus_z.i_cap_len = '0;
    bus_z.i_cap_cur = '0; bus_z.i_cap_perms = '0; bus_z.i_cap_attr = '0; bus_z.i_cap_tag = '0;
    bus_z.i_req_len = '0; bus_z.i_rsp_ready = 1'b0; bus_z.i_trap_clr = 1'b0;
    model_reset();
    @(negedge r_clk);
    apply_reset();

    // zero-length trap pins latency, cause and first capture
    issue(0, 48'd100, 48'd50, 48'd110, 24'(1 << SB_BIT), 1'b1, 48'd0, 48'h40, 0);
    chk("len_trap", 256'({last_trap, last_cause}), 256'({1'b1, 3'd3}));
    chk("len_trap_rec", 256'({bus.o_trap_valid, bus.o_trap_pc, bus.o_trap_count}), 256'({1'b1, 48'h40, 16'd1}));
    // exact fit: new end equals old end
    issue(0, 48'd100, 48'd50, 48'd110, 24'(1 << SB_BIT), 1'b1, 48'd40, 48'h44, 0);
    chk("fit_ok", 256'({last_trap, last_tag, last_base, last_len, last_cur}),
        256'({1'b0, 1'b1, 48'd110, 48'd40, 48'd110}));
    issue(0, 48'd100, 48'd50, 48'd110, 24'(1 << SB_BIT), 1'b1, 48'd41, 48'h80, 0);
    chk("bounds_trap", 256'({last_trap, last_cause}), 256'({1'b1, 3'd4}));
    chk("first_trap_wins", 256'({bus.o_trap_pc, bus.o_trap_count}), 256'({48'h40, 16'd2}));
    issue(0, 48'd100, 48'd50, 48'd110, 24'd0, 1'b0, 48'd0, 48'h90, 0);
    chk("tag_priority", 256'(last_cause), 256'(3'd1));
    issue(0, 48'd100, 48'd50, 48'd110, 24'd0, 1'b1, 48'd40, 48'hA0, 1);
    chk("perm_trap", 256'(last_cause), 256'(3'd2));
    chk("clr_with_trap", 256'({bus.o_trap_valid, bus.o_trap_cause, bus.o_trap_pc, bus.o_trap_count}),
        256'({1'b1, 3'd2, 48'hA0, 16'd4}));
    trap_clr = 1'b1;
    step();
    trap_clr = 1'b0;
    chk("clr_alone", 256'({bus.o_trap_valid, bus.o_trap_pc, bus.o_trap_count}), 256'({1'b0, 48'h0, 16'd4}));
    // end wrapping past 2^W must trap
    issue(1, 48'hFFFF_FFFF_FFF0, 48'd16, 48'hFFFF_FFFF_FFF8, 24'(1 << SB_BIT), 1'b1, 48'd16, 48'hB0, 0);
    chk("wrap_bounds", 256'({last_trap, last_cause}), 256'({1'b1, 3'd4}));

    // zero length is legal on the ALLOW_ZERO_LEN instance
    bus_z.i_req_valid = 2'b01; bus_z.i_cap_base[W-1:0] = 48'd100; bus_z.i_cap_len[W-1:0] = 48'd50;
    bus_z.i_cap_cur[W-1:0] = 48'd110; bus_z.i_cap_perms[PERM_W-1:0] = 24'(1 << SB_BIT);
    bus_z.i_cap_tag = 2'b01; bus_z.i_req_len = '0; bus_z.i_rsp_ready = 1'b1;
    zl_seen = 0; zl_trap = 1'b1; zl_tag = 1'b0; zl_len = '1;
    for (int n = 0; n < 10 && !zl_seen; n++) begin
      step();
      if (bus_z.o_rsp_valid) begin
        zl_seen = 1; zl_trap = bus_z.o_rsp_trap; zl_tag = bus_z.o_rsp_tag; zl_len = bus_z.o_rsp_len;
      end
    end
    bus_z.i_req_valid = '0;
    chk("zl_seen", 256'(zl_seen), 256'(1));
    chk("zl_result", 256'({zl_trap, zl_tag, zl_len}), 256'({1'b0, 1'b1, 48'd0}));
    step();

    // round-robin with both channels continuously requesting
    apply_reset();
    set_req(0, 48'd1000, 48'd100, 48'd1010, 24'(1 << SB_BIT), 1'b1, 48'd20, 48'h100);
    set_req(1, 48'd2000, 48'd100, 48'd2010, 24'(1 << SB_BIT), 1'b1, 48'd20, 48'h200);
    rsp_ready = 1'b1;
    glog_ch.delete(); glog_cyc.delete();
    for (int n = 0; n < 40 && glog_ch.size() < 4; n++) step();
    chk("rr_count", 256'(glog_ch.size()), 256'(4));
    if (glog_ch.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_order", 256'(glog_ch[i]), 256'(i % 2));
      for (int i = 1; i < 4; i++) chk("rr_spacing", 256'(glog_cyc[i] - glog_cyc[i-1]), 256'(3));
    end

    // stalled response holds and blocks new grants
    rsp_ready = 1'b0;
    for (int n = 0; n < 10 && !(m_busy && m_age >= 1); n++) step();
    snap = dut_rsp();
    glog_ch.delete(); glog_cyc.delete();
    repeat (5) begin
      step();
      chk("stall_hold", dut_rsp(), snap);
      chk("stall_valid", 256'(bus.o_rsp_valid), 256'(1));
    end
    chk("stall_no_grant", 256'(glog_ch.size()), 256'(0));
    rsp_ready = 1'b1;
    rq[0].valid = 1'b0; rq[1].valid = 1'b0;
    repeat (4) step();

    // reset while a request sits in CHECK
    apply_reset();
    rq[0].valid = 1'b1; rq[1].valid = 1'b1;
    step();
    chk("pre_rst_grant", 256'(acc_ch), 256'(0));
    apply_reset();
    repeat (4) begin
      step();
      chk("post_rst_rv", 256'(obs_rv), 256'(0));
    end
    rq[0].valid = 1'b1; rq[1].valid = 1'b1;
    glog_ch.delete(); glog_cyc.delete();
    step();
    chk("post_rst_grant_seen", 256'(glog_ch.size()), 256'(1));
    if (glog_ch.size() >= 1) chk("post_rst_grant", 256'(glog_ch[0]), 256'(0));
    rq[0].valid = 1'b0; rq[1].valid = 1'b0;
    repeat (4) step();

    // randomized traffic
    for (int n = 0; n < 700; n++) begin
      for (int c = 0; c < NCH; c++) if (!rq[c].valid && $urandom % 3 == 0) rand_req(c);
      rsp_ready = ($urandom % 4 != 0);
      trap_clr = ($urandom % 16 == 0);
      step();
      if (acc_ch >= 0) rq[acc_ch].valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
